// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and helpers for the data-cache request
//                controller. Holds the controller state encoding, default
//                geometry and the address index/tag extraction helpers.
//                Optional feature macro used by the slice: CACHE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Default geometry
  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_ADDR_W = 32;
  localparam int unsigned C_MEM_AW = 10;
  localparam int unsigned C_IDX_W  = 4;
  localparam int unsigned C_TAG_W  = C_MEM_AW - C_IDX_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Line index: word address bits directly above the byte offset.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: bits between the index and the top of the memory-decoded range.
  // Bits at or above mem_aw are dropped so memory aliases share a line.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned idx_w,
                                           input int unsigned mem_aw);
    return (addr >> (idx_w + 2)) & ((32'd1 << (mem_aw - idx_w - 2)) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_tag_array
//  Description : Direct-mapped, one-word-per-line storage: valid bits, tags
//                and data. One combinational read port, one synchronous
//                write port, a flush-all input and asynchronous reset of the
//                valid bits (tags/data are not reset).
//  Ports       : clk, rst_n        clock / async active-low reset
//                i_flush           clear every valid bit on the next edge
//                i_rd_idx          read index -> o_rd_valid/o_rd_tag/o_rd_data
//                i_wr_en/idx/tag/data  write one line and mark it valid
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned IDX_W  = C_IDX_W,
  parameter int unsigned TAG_W  = C_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data
);

  localparam int unsigned C_LINES = 2 ** IDX_W;

  logic [C_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [C_LINES];
  logic [DATA_W-1:0]  r_data [C_LINES];

  // Flush and write never coincide in the controller; flush is ordered
  // first only so the behaviour is defined if they ever did.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_req_ctrl
//  Description : Initiator side of a word-memory interface. Accepts CPU
//                load/store requests (valid/ready), keeps a direct-mapped,
//                write-through, write-allocate word cache and issues
//                single-cycle mem_read / mem_write strobes.
//  Ports       : clk, rst_n                      clock / async active-low reset
//                cpu_req_valid/ready/we/addr/wdata  request handshake
//                cache_flush                     invalidate all lines (IDLE only)
//                cpu_rsp_valid/rdata             one-cycle response
//                mem_read/mem_write/addr/wdata   memory strobes and operands
//                mem_rdata                       combinational memory read data
//                hit_cnt/miss_cnt                load statistics (CACHE_STATS_EN)
//  Config      : CACHE_STATS_EN - adds saturating load hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_req_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned MEM_AW = C_MEM_AW,
  parameter int unsigned IDX_W  = C_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  input  logic              cache_flush,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned C_LINE_TAG_W = MEM_AW - IDX_W - 2;

  state_t                  r_state;
  logic                    r_we;
  logic [IDX_W-1:0]        w_idx;
  logic [C_LINE_TAG_W-1:0] w_tag;
  logic                    w_line_valid;
  logic [C_LINE_TAG_W-1:0] w_line_tag;
  logic [DATA_W-1:0]       w_line_data;
  logic                    w_hit;
  logic                    w_flush;
  logic                    w_fill_en;
  logic [DATA_W-1:0]       w_fill_data;

  // mem_addr doubles as the registered request address, so lookup and
  // refill both index from it.
  assign w_idx = IDX_W'(addr_index(32'(mem_addr), IDX_W));
  assign w_tag = C_LINE_TAG_W'(addr_tag(32'(mem_addr), IDX_W, MEM_AW));

  assign w_hit         = w_line_valid && (w_line_tag == w_tag);
  assign cpu_req_ready = (r_state == ST_IDLE) && !cache_flush;
  assign w_flush       = (r_state == ST_IDLE) && cache_flush;

  // Line update happens on the same edge as the memory access: refill data
  // for reads, the store data itself for writes (write-allocate).
  assign w_fill_en   = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_fill_data = (r_state == ST_MEM_RD) ? mem_rdata : mem_wdata;

  dcache_tag_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .TAG_W  (C_LINE_TAG_W)
  ) u_tag_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_flush),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_fill_en),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_fill_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_we          <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          cpu_rsp_valid <= 1'b0;
          if (cpu_req_valid && cpu_req_ready) begin
            r_we      <= cpu_req_we;
            mem_addr  <= cpu_req_addr;
            mem_wdata <= cpu_req_wdata;
            r_state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (r_we) begin
            mem_write <= 1'b1;
            r_state   <= ST_MEM_WR;
          end else if (w_hit) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_rdata <= w_line_data;
            r_state       <= ST_RESP;
          end else begin
            mem_read <= 1'b1;
            r_state  <= ST_MEM_RD;
          end
        end
        ST_MEM_RD: begin
          mem_read      <= 1'b0;
          cpu_rsp_valid <= 1'b1;
          cpu_rsp_rdata <= mem_rdata;
          r_state       <= ST_RESP;
        end
        ST_MEM_WR: begin
          mem_write     <= 1'b0;
          cpu_rsp_valid <= 1'b1;
          cpu_rsp_rdata <= '0;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          cpu_rsp_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          cpu_rsp_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Load statistics; saturate rather than wrap, and survive cache_flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((r_state == ST_LOOKUP) && !r_we) begin
      if (w_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_req_ctrl
//  Description : Self-checking bench for dcache_req_ctrl with a word memory
//                model, a behavioural cache/latency reference model checked
//                every cycle, directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cache_flush;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_req_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cache_flush   (cache_flush),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
  endfunction

  // Backing memory: async read, sync write, decodes addr[9:2].
  logic [31:0] mem [0:255];
  bit          mem_init_done = 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 16-line direct-mapped table, a shadow memory and the
  // documented latencies (hit 2, miss 3, store 3 cycles after accept).
  initial begin : model
    logic [31:0] m_mem [0:255];
    bit          m_v [16];
    int          m_t [16];
    bit          busy;
    int          phase, lat, kind;  // kind: 0 load hit, 1 load miss, 2 store
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          e_rsp, e_rd, e_wr, e_rdy;
    int          idx, tg, wd;
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    busy = 1'b0; phase = 0; lat = 0; kind = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        check_b("rst_rsp_valid", cpu_rsp_valid, 1'b0);
        check_b("rst_mem_read",  mem_read,      1'b0);
        check_b("rst_mem_write", mem_write,     1'b0);
        check("rst_mem_addr",    mem_addr,      32'h0);
        check("rst_mem_wdata",   mem_wdata,     32'h0);
        check("rst_rsp_rdata",   cpu_rsp_rdata, 32'h0);
      end else begin
        if (busy) phase++;
        e_rsp = busy && (phase == lat);
        e_rd  = busy && (kind == 1) && (phase == 2);
        e_wr  = busy && (kind == 2) && (phase == 2);
        e_rdy = !busy && !cache_flush;
        check_b("cyc_ready",     cpu_req_ready, e_rdy);
        check_b("cyc_rsp_valid", cpu_rsp_valid, e_rsp);
        check_b("cyc_mem_read",  mem_read,      e_rd);
        check_b("cyc_mem_write", mem_write,     e_wr);
        if (e_rsp) check("cyc_rsp_rdata", cpu_rsp_rdata, m_rdata);
        if (e_rd || e_wr) check("cyc_mem_addr", mem_addr, m_addr);
        if (e_wr) check("cyc_mem_wdata", mem_wdata, m_wdata);
        // What the coming edge does
        if (busy) begin
          if (phase == lat) busy = 1'b0;
        end else if (cache_flush) begin
          for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        end else if (cpu_req_valid) begin
          m_addr  = cpu_req_addr;
          m_wdata = cpu_req_wdata;
          idx = int'((m_addr >> 2) & 32'hF);
          tg  = int'((m_addr >> 6) & 32'hF);
          wd  = int'((m_addr >> 2) & 32'hFF);
          busy  = 1'b1;
          phase = 0;
          if (cpu_req_we) begin
            kind = 2; lat = 3; m_rdata = 32'h0;
            m_mem[wd] = m_wdata;
            m_v[idx] = 1'b1; m_t[idx] = tg;
          end else if (m_v[idx] && m_t[idx] == tg) begin
            kind = 0; lat = 2; m_rdata = m_mem[wd];
          end else begin
            kind = 1; lat = 3; m_rdata = m_mem[wd];
            m_v[idx] = 1'b1; m_t[idx] = tg;
          end
        end
      end
    end
  end

  // One request; returns response data, accept-to-response latency and the
  // strobe activity observed while it was in flight.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit fl, output logic [31:0] rd, output int lat,
                        output int nrd, output int nwr, output logic [31:0] maddr);
    int  guard;
    bit  got;
    rd = '0; lat = 0; nrd = 0; nwr = 0; maddr = '0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    if (fl) begin
      cache_flush = 1'b1;
      @(negedge clk);
      check_b("flush_holds_ready", cpu_req_ready, 1'b0);
      @(posedge clk); #1;
      cache_flush = 1'b0;
    end
    guard = 0;
    got   = 1'b0;
    while (!got && guard < 10) begin
      @(negedge clk);
      guard++;
      got = cpu_req_ready;
    end
    check_b("req_accept_in_time", got, 1'b1);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    if (got) begin
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (mem_read) nrd++;
        if (mem_write) begin nwr++; maddr = mem_addr; end
        if (cpu_rsp_valid) begin got = 1'b1; rd = cpu_rsp_rdata; end
      end
      check_b("rsp_in_time", got, 1'b1);
    end
  endtask

  initial begin : stim
    logic [31:0] rd, maddr, a;
    int          lat, nrd, nwr;
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0; cache_flush = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // 1: cold load
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t1_rdata", rd, 32'hDEAD_BEEF);
    check("t1_latency", lat, 3);
    check("t1_mem_read_cycles", nrd, 1);
`ifdef CACHE_STATS_EN
    check("t1_miss_cnt", miss_cnt, 32'd1);
`endif
    // 2: same load hits
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t2_rdata", rd, 32'hDEAD_BEEF);
    check("t2_latency", lat, 2);
    check("t2_mem_read_cycles", nrd, 0);
`ifdef CACHE_STATS_EN
    check("t2_hit_cnt", hit_cnt, 32'd1);
`endif
    // 3: store then load-hit of the written word
    do_req(1'b1, 32'h40, 32'h1234_5678, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t3_store_rdata", rd, 32'h0);
    check("t3_store_latency", lat, 3);
    check("t3_mem_write_cycles", nwr, 1);
    check("t3_mem_write_addr", maddr, 32'h40);
    do_req(1'b0, 32'h40, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t3_load_rdata", rd, 32'h1234_5678);
    check("t3_load_latency", lat, 2);
    // 4: aliasing and index conflict
    do_req(1'b0, 32'h0, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t4_load0_rdata", rd, 32'h5A00_00C3);
    do_req(1'b0, 32'h400, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t4_alias_rdata", rd, 32'h5A00_00C3);
    check("t4_alias_latency", lat, 2);
    do_req(1'b0, 32'h50, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t4_conflict_rdata", rd, 32'h4E14_14D7);
    check("t4_conflict_latency", lat, 3);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t4_refill_latency", lat, 3);
    // 5: flush wins over a simultaneous request; cached line then misses
    do_req(1'b0, 32'h10, 32'h0, 1'b1, rd, lat, nrd, nwr, maddr);
    check("t5_rdata", rd, 32'hDEAD_BEEF);
    check("t5_latency", lat, 3);
    // 6: reset in the middle of a memory read
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h80;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    check_b("t6_mem_read_active", mem_read, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_b("t6_mem_read_drop", mem_read, 1'b0);
    check_b("t6_no_rsp", cpu_rsp_valid, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check_b("t6_ready_after_reset", cpu_req_ready, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, lat, nrd, nwr, maddr);
    check("t6_reload_latency", lat, 3);
    check("t6_reload_rdata", rd, 32'hDEAD_BEEF);

    // Randomized traffic over a small footprint with aliases
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 3)) << 10)
          | 32'($urandom_range(0, 3));
      do_req(($urandom_range(0, 2) == 0), a, $urandom, ($urandom_range(0, 15) == 0),
             rd, lat, nrd, nwr, maddr);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
